// File: rtl/mem2_stage_if.sv
// Bus bundle around the MEM2 stage: MEM1 input bus, writeback bus and MEM2->ID forwarding bus.
interface mem2_stage_if #(
    parameter int MEM12MEM2_WD = 210,
    parameter int MEM22WB_WD   = 134,
    parameter int MEM22ID_WD   = 70
);
    logic [MEM12MEM2_WD-1:0] mem12mem2_bus;
    logic [MEM22WB_WD-1:0]   mem22wb_bus;
    logic [MEM22ID_WD-1:0]   mem22id_fwd;

    modport master (
        output mem12mem2_bus,
        input  mem22wb_bus,
        input  mem22id_fwd
    );

    modport slave (
        input  mem12mem2_bus,
        output mem22wb_bus,
        output mem22id_fwd
    );
endinterface

// File: rtl/mem2_stage.sv
// MEM2 pipeline stage: registers the MEM1 bus, aligns/extends load data, selects write data
// and keeps the 64-bit retired-instruction counter.
module mem2_stage #(
    parameter int MEM12MEM2_WD = 210,
    parameter int MEM22WB_WD   = 134,
    parameter int MEM22ID_WD   = 70,
    parameter int STALL_WD     = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [STALL_WD-1:0] stall,
    mem2_stage_if.slave         bus_if,
    output logic [63:0]         instret
);

    logic [MEM12MEM2_WD-1:0] bus_q, bus_d;
    logic [63:0]             instret_q, instret_d;

    logic [63:0] sram_rdata;
    logic [6:0]  lsu_op;
    logic [3:0]  data_ram_sel;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] ex_result;
    logic [31:0] pc;
    logic [31:0] inst;

    assign {sram_rdata, lsu_op, data_ram_sel, sel_rf_res, rf_we, rf_waddr,
            ex_result, pc, inst} = bus_q;

    logic       valid;
    logic [2:0] off;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;
    logic [63:0] load_data;
    logic [63:0] rf_wdata;
    logic        we_gated;

    assign valid = (inst != '0);
    assign off   = ex_result[2:0];

    // Address bits below the access size are dropped, so every access is naturally aligned.
    assign byte_v = sram_rdata[{off, 3'b000} +: 8];
    assign half_v = sram_rdata[{off[2:1], 4'b0000} +: 16];
    assign word_v = sram_rdata[{off[2], 5'b00000} +: 32];

    always_comb begin
        load_data = '0;
        if (lsu_op[0])      load_data = {{56{byte_v[7]}}, byte_v};
        else if (lsu_op[1]) load_data = {{48{half_v[15]}}, half_v};
        else if (lsu_op[2]) load_data = {{32{word_v[31]}}, word_v};
        else if (lsu_op[3]) load_data = sram_rdata;
        else if (lsu_op[4]) load_data = {56'd0, byte_v};
        else if (lsu_op[5]) load_data = {48'd0, half_v};
        else if (lsu_op[6]) load_data = {32'd0, word_v};
    end

    assign rf_wdata = sel_rf_res ? load_data : ex_result;
    assign we_gated = rf_we & (rf_waddr != '0);

    assign bus_if.mem22wb_bus = {we_gated, rf_waddr, rf_wdata, pc, inst};
    assign bus_if.mem22id_fwd = {we_gated, rf_waddr, rf_wdata};
    assign instret            = instret_q;

    // A stalled instruction is counted on the edge it leaves the register, not while held.
    always_comb begin
        bus_d = bus_q;
        if (flush)                      bus_d = '0;
        else if (stall[5] && !stall[6]) bus_d = '0;
        else if (!stall[5])             bus_d = bus_if.mem12mem2_bus;

        instret_d = instret_q;
        if (valid && !stall[6] && !flush) instret_d = instret_q + 64'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q     <= '0;
            instret_q <= '0;
        end else begin
            bus_q     <= bus_d;
            instret_q <= instret_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{data_ram_sel, stall};

endmodule

// File: doc/mem2_stage.md
Name: mem2_stage

Overview:
- Final memory stage, directly downstream of the MEM1 stage. Consumes MEM1's bus: registered SRAM read data plus instruction control.
- Registers the bus under stall/flush control. Aligns and sign/zero-extends load data, then selects the register-file write data.
- Drives the writeback bus and the MEM2→ID forwarding bus.
- Keeps a 64-bit retired-instruction counter.

Parameters:
- MEM12MEM2_WD, 210, input bus width.
- MEM22WB_WD, 134, writeback bus width.
- MEM22ID_WD, 70, forwarding bus width.
- STALL_WD, 7, stall bus width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  pipeline flush.
- stall  in  STALL_WD  stall vector; bits 5 and 6 used.
- mem12mem2_bus  in  MEM12MEM2_WD  fields MSB→LSB: sram_rdata[63:0], lsu_op[6:0], data_ram_sel[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[63:0], pc[31:0], inst[31:0].
- mem22wb_bus  out  MEM22WB_WD  {rf_we, rf_waddr, rf_wdata[63:0], pc, inst}.
- mem22id_fwd  out  MEM22ID_WD  {rf_we, rf_waddr, rf_wdata}.
- instret  out  64  retired-instruction count.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset: the bus register and instret clear to 0 immediately when rst_n falls. All outputs read 0, because the all-zero bus register decodes to zero outputs.
- Bus register update, priority high→low:
  - flush → clear to 0.
  - stall[5] & !stall[6] → clear to 0 (insert bubble).
  - !stall[5] → capture mem12mem2_bus.
  - Otherwise hold.
- Latency: one cycle from input to outputs. Outputs are combinational from the register.
- Valid: valid = (inst != 0). A bubble is the all-zero register.
- Load extraction uses off = ex_result[2:0]. Low bits below the access size are ignored; no misalignment trap.
  - Byte: rdata[8*off +: 8].
  - Half: rdata[16*off[2:1] +: 16].
  - Word: rdata[32*off[2] +: 32].
  - Double: full 64 bits.
- lsu_op is one-hot:
  - bit0 LB, bit1 LH, bit2 LW, bit3 LD: sign-extend to 64 bits.
  - bit4 LBU, bit5 LHU, bit6 LWU: zero-extend to 64 bits.
  - If several bits are set, the lowest set bit wins.
- Write data:
  - rf_wdata = load_data when sel_rf_res=1, else ex_result.
  - sel_rf_res=1 with lsu_op=0 gives rf_wdata = 0.
- data_ram_sel is ignored by this stage.
- Write-enable gating: output rf_we = reg.rf_we & (rf_waddr != 0). The forward bus uses the same gated rf_we.
- instret:
  - Increments by 1 on a rising edge when valid & !stall[6] & !flush.
  - A held (stalled) instruction is counted once, on the edge it leaves.
  - Wraps modulo 2^64.
  - A flush in the same cycle suppresses the count.
- Simultaneous events: flush beats all stalls. Reset mid-operation discards the register contents and the counter.

Test Plan:
- Reset: rst_n=0 mid-run with a valid instruction held → all outputs 0 and instret=0, asynchronously before the next edge.
- LB: rdata=0x8877_6655_4433_2211, ex_result=0x...1003, lsu_op=0000001, sel_rf_res=1, rf_waddr=5 → next cycle rf_wdata=0x0000_0000_0000_0044, rf_we=1. Repeat with rdata byte 3=0x84 → 0xFFFF_FFFF_FFFF_FF84. Repeat with LBU → 0x84.
- LH/LW/LWU: rdata=0x8000_0001_F000_0002.
  - LH at off=6 → 0xFFFF_FFFF_FFFF_8000.
  - LW at off=4 → 0xFFFF_FFFF_8000_0001.
  - LWU at off=4 → 0x8000_0001.
  - LD → full rdata.
- Stall/bubble:
  - stall[5]=1, stall[6]=0 for 2 cycles → outputs all-zero; instret does not change.
  - stall[5]=stall[6]=1 → register and outputs held; instret frozen; it increments once after release.
- Flush and x0: flush with stall=0 → bus cleared, no instret increment. Valid ALU op with rf_waddr=0, ex_result=0x55 → rf_we=0 on both output buses, instret +1.
